silu_input_cast_stream: RTL

//  Streaming requantiser directly upstream of the 6-bit SiLU lookup stage. Each lane of a

---
 rtl/silu_input_cast_stream.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/silu_input_cast_stream.sv
// rtl/silu_input_cast_stream.sv - round/saturate fixed-point lanes to 6.3 SiLU codes behind a 2-entry skid buffer
// Keeps a saturating count of clamped lanes, counted when a beat is accepted.
module silu_input_cast_stream #(
  parameter int DATA_IN_0_PRECISION_0       = 16,
  parameter int DATA_IN_0_PRECISION_1       = 8,
  parameter int DATA_OUT_0_PRECISION_0      = 6,
  parameter int DATA_OUT_0_PRECISION_1      = 3,
  parameter int DATA_IN_0_PARALLELISM_DIM_0 = 4,
  parameter int SAT_CNT_WIDTH               = 16
) (
  input  logic                                                    clk,
  input  logic                                                    rst,
  input  logic [DATA_IN_0_PARALLELISM_DIM_0*DATA_IN_0_PRECISION_0-1:0]  data_in_0,
  input  logic                                                    data_in_0_valid,
  output logic                                                    data_in_0_ready,
  output logic [DATA_IN_0_PARALLELISM_DIM_0*DATA_OUT_0_PRECISION_0-1:0] data_out_0,
  output logic                                                    data_out_0_valid,
  input  logic                                                    data_out_0_ready,
  input  logic                                                    clear_sat,
  output logic [SAT_CNT_WIDTH-1:0]                                sat_count
);

  localparam int IN_W  = DATA_IN_0_PRECISION_0;
  localparam int IN_F  = DATA_IN_0_PRECISION_1;
  localparam int OUT_W = DATA_OUT_0_PRECISION_0;
  localparam int OUT_F = DATA_OUT_0_PRECISION_1;
  localparam int P     = DATA_IN_0_PARALLELISM_DIM_0;
  localparam int S     = IN_F - OUT_F;
  localparam int POP_W = $clog2(P + 1);
  localparam int MAX_I = (2 ** (OUT_W - 1)) - 1;
  localparam int MIN_I = -(2 ** (OUT_W - 1));
  localparam logic signed [IN_W:0] SAT_MAX = (IN_W + 1)'(MAX_I);
  localparam logic signed [IN_W:0] SAT_MIN = (IN_W + 1)'(MIN_I);

  if (IN_F < OUT_F || OUT_W > IN_W) begin : g_bad_params
    $error("silu_input_cast_stream: unsupported precision combination");
  end

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t                 r_state, w_state_next;
  logic                   r_ready;
  logic [P*OUT_W-1:0]     r_out, r_skid;
  logic [SAT_CNT_WIDTH-1:0] r_sat_cnt;

  logic [P*OUT_W-1:0]     w_code;
  logic [P-1:0]           w_sat;
  logic [POP_W-1:0]       w_sat_pop;
  logic                   w_accept, w_pop;
  logic                   w_load_out, w_load_skid, w_out_from_skid;
  logic [SAT_CNT_WIDTH:0] w_cnt_sum;

  // Widen by one bit so the rounding offset never wraps the most positive input.
  for (genvar g = 0; g < P; g++) begin : g_lane
    logic signed [IN_W:0] w_ext, w_shr;
    assign w_ext = {data_in_0[g*IN_W + IN_W - 1], data_in_0[g*IN_W +: IN_W]};
    if (S > 0) begin : g_round
      localparam logic signed [IN_W:0] RND = (IN_W + 1)'(2 ** (S - 1));
      logic signed [IN_W:0] w_sum;
      assign w_sum = w_ext + RND;
      assign w_shr = w_sum >>> S;
    end else begin : g_pass
      assign w_shr = w_ext;
    end
    always_comb begin
      w_sat[g] = 1'b0;
      w_code[g*OUT_W +: OUT_W] = w_shr[OUT_W-1:0];
      if (w_shr > SAT_MAX) begin
        w_sat[g] = 1'b1;
        w_code[g*OUT_W +: OUT_W] = SAT_MAX[OUT_W-1:0];
      end else if (w_shr < SAT_MIN) begin
        w_sat[g] = 1'b1;
        w_code[g*OUT_W +: OUT_W] = SAT_MIN[OUT_W-1:0];
      end
    end
  end

  always_comb begin
    w_sat_pop = '0;
    for (int i = 0; i < P; i++) begin
      w_sat_pop = w_sat_pop + POP_W'(w_sat[i]);
    end
  end

  assign w_accept = data_in_0_valid && r_ready;
  assign w_pop    = (r_state != EMPTY) && data_out_0_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= EMPTY;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_ready <= (w_state_next != FULL);
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_load_out      = 1'b0;
    w_load_skid     = 1'b0;
    w_out_from_skid = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_accept) begin
          w_load_out   = 1'b1;
          w_state_next = ONE;
        end
      end
      ONE: begin
        if (w_accept && w_pop) begin
          w_load_out = 1'b1;
        end else if (w_accept) begin
          w_load_skid  = 1'b1;
          w_state_next = FULL;
        end else if (w_pop) begin
          w_state_next = EMPTY;
        end
      end
      FULL: begin
        if (w_pop) begin
          w_load_out      = 1'b1;
          w_out_from_skid = 1'b1;
          w_state_next    = ONE;
        end
      end
      default: w_state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out  <= '0;
      r_skid <= '0;
    end else begin
      if (w_load_out) r_out <= w_out_from_skid ? r_skid : w_code;
      if (w_load_skid) r_skid <= w_code;
    end
  end

  // One extra bit catches the carry so the count sticks at all-ones.
  assign w_cnt_sum = {1'b0, r_sat_cnt} + (SAT_CNT_WIDTH + 1)'(w_sat_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sat_cnt <= '0;
    end else if (w_accept && clear_sat) begin
      r_sat_cnt <= SAT_CNT_WIDTH'(w_sat_pop);
    end else if (w_accept) begin
      r_sat_cnt <= w_cnt_sum[SAT_CNT_WIDTH] ? '1 : w_cnt_sum[SAT_CNT_WIDTH-1:0];
    end else if (clear_sat) begin
      r_sat_cnt <= '0;
    end
  end

  assign data_in_0_ready  = r_ready;
  assign data_out_0       = r_out;
  assign data_out_0_valid = (r_state != EMPTY);
  assign sat_count        = r_sat_cnt;

endmodule
